// File: rtl/fib_pkg.sv
// Shared types and helpers for the multi-lane Fibonacci stream generator.
package fib_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fib_state_e;

    // LSB position of a lane inside a packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/fib_lane_chain.sv
// Combinational Fibonacci lane chain: extends (a, b) to LANES+2 terms with
// per-term overflow flags that propagate to every later term.
module fib_lane_chain
    import fib_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned LANES = 2
) (
    input  logic [W-1:0]              a_i,
    input  logic [W-1:0]              b_i,
    input  logic                      ca_i,
    input  logic                      cb_i,
    output logic [LANES+1:0][W-1:0]   t_o,
    output logic [LANES+1:0]          c_o
);

    logic [W:0] sum;

    always_comb begin
        t_o    = '0;
        c_o    = '0;
        sum    = '0;
        t_o[0] = a_i;
        t_o[1] = b_i;
        c_o[0] = ca_i;
        c_o[1] = cb_i;
        for (int i = 2; i <= int'(LANES) + 1; i++) begin
            sum    = {1'b0, t_o[i-1]} + {1'b0, t_o[i-2]};
            t_o[i] = sum[W-1:0];
            c_o[i] = sum[W] | c_o[i-1] | c_o[i-2];
        end
    end

endmodule

// File: rtl/fib_stream_gen.sv
// Multi-lane Fibonacci stream generator with start/stop and sticky overflow.
// Build option FIB_STREAM_OVF_STOP_EN: end the stream at the first overflowed beat.
module fib_stream_gen
    import fib_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [W-1:0]         seed_a,
    input  logic [W-1:0]         seed_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_num,
    output logic [LANES-1:0]     out_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    fib_state_e state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    // Overflow flags of the held terms a and b, so a wrapped term stays marked
    // when it moves into lane 0 or 1 of a later beat.
    logic ca_q, ca_d, cb_q, cb_d;
    logic ovf_q, ovf_d;

    logic [LANES+1:0][W-1:0] t;
    logic [LANES+1:0]        c;
    logic                    emitted_ovf;

    fib_lane_chain #(
        .W     (W),
        .LANES (LANES)
    ) u_chain (
        .a_i  (a_q),
        .b_i  (b_q),
        .ca_i (ca_q),
        .cb_i (cb_q),
        .t_o  (t),
        .c_o  (c)
    );

    assign emitted_ovf = |c[LANES-1:0];

    always_comb begin
        out_num = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            out_num[lane_lsb(i, W) +: W] = t[i];
        end
    end

    assign out_valid = (state_q == StRun);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign overflow  = ovf_q;

`ifdef FIB_STREAM_OVF_STOP_EN
    assign out_mask = out_valid ? ~c[LANES-1:0] : '0;
`else
    assign out_mask = out_valid ? '1 : '0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        ovf_d   = ovf_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        a_d     = seed_a;
                        b_d     = seed_b;
                        ca_d    = 1'b0;
                        cb_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                StRun: begin
                    if (out_ready) begin
                        ovf_d = ovf_q | emitted_ovf;
`ifdef FIB_STREAM_OVF_STOP_EN
                        // Also end when the next beat's lane 0 would be invalid.
                        if (|c[LANES:0]) begin
                            state_d = StDone;
                        end else begin
                            a_d  = t[LANES];
                            b_d  = t[LANES+1];
                            ca_d = c[LANES];
                            cb_d = c[LANES+1];
                        end
`else
                        a_d  = t[LANES];
                        b_d  = t[LANES+1];
                        ca_d = c[LANES];
                        cb_d = c[LANES+1];
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            ca_q    <= 1'b0;
            cb_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
